layer2_pool_collector: RTL
==========================

Name: layer2_pool_collector

Overview:
- Receive-side consumer of the Layer-2 convolution output stream: 32 channels × 16 bit per beat, strobed by the conv block's ready.
- Performs 2×2 stride-2 max pooling over the IMG_W×IMG_H conv output map, which arrives one pixel per beat in raster order.
- Emits one pooled 32-channel pixel per completed 2×2 window to the next layer.
- Holds per-frame counters and a half-width line buffer; the conv block has no backpressure, so this block never stalls its input.

Parameters:
- BITS, 16, width of one channel sample
- BITS_SHIFT, 4, log2(BITS); used for lane slicing
- CH_NUM, 32, channels per beat
- IMG_W, 8, conv output width in pixels (must be even)
- IMG_H, 8, conv output height in pixels (must be even)

Ports:
- clk_in, input, 1, single clock, rising edge
- rst, input, 1, synchronous active-high reset
- frame_start, input, 1, one-cycle pulse that arms a new frame
- data_in, input, CH_NUM<<BITS_SHIFT, conv output; lane n = bits [n*16+15 : n*16], unsigned (post-ReLU)
- data_valid, input, 1, beat strobe from conv ready
- pool_out, output, CH_NUM<<BITS_SHIFT, pooled pixel, same lane layout
- pool_valid, output, 1, one-cycle strobe qualifying pool_out
- frame_done, output, 1, one-cycle pulse after the last pooled pixel of a frame
- busy, output, 1, high while in ACTIVE

Behaviour:
- Interface: one clock clk_in; reset rst is synchronous and active-high.
- Reset values: pool_out=0, pool_valid=0, frame_done=0, busy=0, state=IDLE, col=0, row=0, line buffer contents don't-care.
- States:
  - IDLE: data_valid is ignored. frame_start → ACTIVE with col=row=0.
  - ACTIVE: each data_valid beat is accepted.
    - col increments; at IMG_W-1 it wraps to 0 and row increments.
    - Beat with row=IMG_H-1 and col=IMG_W-1 → DONE.
  - DONE: one cycle with frame_done=1, then → IDLE.
- Pooling, per channel lane, all compares unsigned 16 bit:
  - Even row, even col: hreg ← lane.
  - Even row, odd col: linebuf[col>>1] ← max(hreg, lane).
  - Odd row, even col: hreg ← max(linebuf[col>>1], lane).
  - Odd row, odd col: pool_out ← max(hreg, lane); pool_valid=1 in the next cycle.
- Latency: pool_valid is asserted exactly 1 cycle after the accepting odd-row/odd-col beat.
  - For the final window, frame_done and busy=0 appear the cycle after pool_valid.
- Output rate: IMG_W/2 × IMG_H/2 pool_valid pulses per frame (16 at defaults).
- pool_out holds its last value between strobes.
- Line buffer: IMG_W/2 entries × (CH_NUM×BITS) bits; a register array is acceptable.
- Boundary conditions:
  - frame_start while ACTIVE: restart. Counters clear, hreg and line buffer contents are discarded, and any data_valid in the same cycle is dropped.
  - frame_start and data_valid together in IDLE: the beat is not accepted; the first accepted beat is in the next cycle.
  - frame_start during DONE: frame_done still pulses, and state goes to ACTIVE instead of IDLE.
  - data_valid gaps of any length: no effect on state.
  - rst mid-frame: all outputs and state return to reset values in the next cycle; no pool_valid or frame_done is emitted for the aborted frame.

Optional Feature:
- Macro: POOL_AVG_EN.
- Defined: average pooling.
  - Partial sums are kept at BITS+2 bits; linebuf width grows accordingly.
  - pool_out lane = (a+b+c+d)>>2, truncated, so no overflow is possible.
- Undefined: max pooling as described above.
- Latency, handshakes and counters are identical in both builds.

Test Plan:
- Max pool, ramp: frame_start, then 64 contiguous beats with every lane = raster index (0..63) → 16 pool_valid pulses; lane values 9,11,13,15,25,...,63; then frame_done one cycle after the last.
- Per-lane independence: lane n = n×100 + index, with lane 31 fixed at 0xFFFF → lane 31 outputs 0xFFFF, and no carry/borrow into lane 30.
- Gapped input: same stream as the ramp test, with data_valid deasserted for 3 cycles between every beat → identical output sequence; each pool_valid 1 cycle after its triggering beat.
- Restart: frame_start at beat 20, then a full new ramp frame → exactly 16 outputs, all matching the ramp test; no output derived from pre-restart data.
- Reset/idle: rst at beat 40; afterwards 10 data_valid beats with no frame_start → pool_valid never asserts; busy=0.
- POOL_AVG_EN build: four 0xFFFF samples in one window → 0xFFFF; samples 1,2,3,5 → 0x0002 (11>>2).

Source files
------------

// File: rtl/layer2_pool_collector.sv
`default_nettype none
// ============================================================================
//  Module   : layer2_pool_collector
//  Brief    : 2x2 stride-2 pooling of the Layer-2 conv output stream
//             (CH_NUM lanes of BITS bits, one pixel per beat, raster order).
//             Build macro POOL_AVG_EN selects average pooling; otherwise max.
//             IMG_W must be even and >= 4, IMG_H even and >= 2.
//  Revision : 1.0 - initial release
// ============================================================================
module layer2_pool_collector #(
    parameter int BITS       = 16,
    parameter int BITS_SHIFT = 4,
    parameter int CH_NUM     = 32,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                           clk_in,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic [(CH_NUM<<BITS_SHIFT)-1:0] data_in,
    input  logic                           data_valid,
    output logic [(CH_NUM<<BITS_SHIFT)-1:0] pool_out,
    output logic                           pool_valid,
    output logic                           frame_done,
    output logic                           busy
);

    localparam int c_DW   = CH_NUM << BITS_SHIFT;
`ifdef POOL_AVG_EN
    // Two guard bits hold the sum of up to four samples without overflow.
    localparam int c_SW   = BITS + 2;
`else
    localparam int c_SW   = BITS;
`endif
    localparam int c_HW   = CH_NUM * c_SW;
    localparam int c_CW   = $clog2(IMG_W);
    localparam int c_RW   = $clog2(IMG_H);
    localparam int c_LB_N = IMG_W / 2;

    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACTIVE = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]      r_state_q, w_state_d;
    logic [c_CW-1:0] r_col_q, w_col_d;
    logic [c_RW-1:0] r_row_q, w_row_d;
    logic [c_HW-1:0] r_hreg_q, w_hreg_d;
    logic [c_HW-1:0] r_linebuf_q [c_LB_N];
    logic [c_HW-1:0] w_linebuf_d [c_LB_N];
    logic [c_DW-1:0] r_pool_out_q, w_pool_out_d;
    logic            r_pool_valid_q, w_pool_valid_d;
    logic            r_frame_done_q, w_frame_done_d;
    logic            r_busy_q, w_busy_d;

    logic            w_accept;
    logic            w_last_beat;
    logic [c_HW-1:0] w_lb_rd;
    logic [c_HW-1:0] w_even_val;   // new hreg value on an even column
    logic [c_HW-1:0] w_pair_val;   // hreg combined with lane, stored to the line buffer
    logic [c_DW-1:0] w_final_val;  // completed window result

    assign w_last_beat = (r_row_q == c_ROW_LAST) && (r_col_q == c_COL_LAST);
    assign w_lb_rd     = r_linebuf_q[r_col_q[c_CW-1:1]];

    // Per-lane combine operators; lanes are fully independent.
    for (genvar n = 0; n < CH_NUM; n++) begin : g_lane
        logic [c_SW-1:0] w_x;
        logic [c_SW-1:0] w_h;
        logic [c_SW-1:0] w_lb;
        assign w_x  = c_SW'(data_in[(n << BITS_SHIFT) +: BITS]);
        assign w_h  = r_hreg_q[n*c_SW +: c_SW];
        assign w_lb = w_lb_rd[n*c_SW +: c_SW];
`ifdef POOL_AVG_EN
        assign w_even_val[n*c_SW +: c_SW]          = r_row_q[0] ? (w_lb + w_x) : w_x;
        assign w_pair_val[n*c_SW +: c_SW]          = w_h + w_x;
        assign w_final_val[(n << BITS_SHIFT) +: BITS] = BITS'((w_h + w_x) >> 2);
`else
        logic [c_SW-1:0] w_mx;
        assign w_mx = (w_h > w_x) ? w_h : w_x;
        assign w_even_val[n*c_SW +: c_SW]          = r_row_q[0] ? ((w_lb > w_x) ? w_lb : w_x) : w_x;
        assign w_pair_val[n*c_SW +: c_SW]          = w_mx;
        assign w_final_val[(n << BITS_SHIFT) +: BITS] = BITS'(w_mx);
`endif
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state_q <= c_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // FSM next-state: frame_start always (re)arms, even out of DONE
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE:   if (frame_start) w_state_d = c_ACTIVE;
            c_ACTIVE: begin
                if (frame_start) begin
                    w_state_d = c_ACTIVE;
                end else if (w_accept && w_last_beat) begin
                    w_state_d = c_DONE;
                end
            end
            c_DONE:   w_state_d = frame_start ? c_ACTIVE : c_IDLE;
            default:  w_state_d = c_IDLE;
        endcase
    end

    // FSM outputs: beat acceptance and the registered strobes
    always_comb begin
        w_accept       = (r_state_q == c_ACTIVE) && data_valid && !frame_start;
        w_busy_d       = (r_state_q == c_ACTIVE);
        w_frame_done_d = (r_state_q == c_DONE);
        w_pool_valid_d = w_accept && r_row_q[0] && r_col_q[0];
    end

    // Raster counters and pooling datapath update for an accepted beat
    always_comb begin
        w_col_d      = r_col_q;
        w_row_d      = r_row_q;
        w_hreg_d     = r_hreg_q;
        w_linebuf_d  = r_linebuf_q;
        w_pool_out_d = r_pool_out_q;
        if (frame_start) begin
            w_col_d = '0;
            w_row_d = '0;
        end else if (w_accept) begin
            if (r_col_q == c_COL_LAST) begin
                w_col_d = '0;
                w_row_d = w_last_beat ? '0 : r_row_q + c_RW'(1);
            end else begin
                w_col_d = r_col_q + c_CW'(1);
            end
            case ({r_row_q[0], r_col_q[0]})
                2'b00, 2'b10: w_hreg_d = w_even_val;
                2'b01:        w_linebuf_d[r_col_q[c_CW-1:1]] = w_pair_val;
                default:      w_pool_out_d = w_final_val;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_col_q        <= '0;
            r_row_q        <= '0;
            r_hreg_q       <= '0;
            r_pool_out_q   <= '0;
            r_pool_valid_q <= 1'b0;
            r_frame_done_q <= 1'b0;
            r_busy_q       <= 1'b0;
        end else begin
            r_col_q        <= w_col_d;
            r_row_q        <= w_row_d;
            r_hreg_q       <= w_hreg_d;
            r_pool_out_q   <= w_pool_out_d;
            r_pool_valid_q <= w_pool_valid_d;
            r_frame_done_q <= w_frame_done_d;
            r_busy_q       <= w_busy_d;
        end
    end

    // Line buffer storage; contents are don't-care after reset
    always_ff @(posedge clk_in) begin
        r_linebuf_q <= w_linebuf_d;
    end

    assign pool_out   = r_pool_out_q;
    assign pool_valid = r_pool_valid_q;
    assign frame_done = r_frame_done_q;
    assign busy       = r_busy_q;

endmodule
`default_nettype wire
